key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Upstream input stage of the tug-of-war game: converts the two raw, active-low player pushbuttons into clean single-cycle L/R move pulses for the light chain.
- Per key: a multi-flop synchronizer, then a debounce filter, then a rising-edge one-shot.
- Holding a key produces exactly one pulse.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count per key (minimum 2).
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized level must differ from the debounced level before the debounced level flips (minimum 1; the board build uses a large value).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- key_l_n  input  1  raw left key, active-low, asynchronous to Clock.
- key_r_n  input  1  raw right key, active-low, asynchronous to Clock.
- L  output  1  one-cycle pulse per debounced left press.
- R  output  1  one-cycle pulse per debounced right press.
- held_l  output  1  debounced left level (1 = pressed).
- held_r  output  1  debounced right level (1 = pressed).

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - sync flops = 1 (released);
  - debounce state = RELEASED; counter = 0; prev flop = 0;
  - L = R = held_l = held_r = 0.
- Per-key FSM, two states: RELEASED and PRESSED.
  - s = synchronized key, inverted, so 1 = pressed.
  - RELEASED: s=1 increments the counter; s=0 clears it.
    - At the edge where the counter would reach DEBOUNCE_CYCLES: go to PRESSED, counter <= 0.
  - PRESSED: symmetric rule on s=0, returning to RELEASED.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). It never exceeds DEBOUNCE_CYCLES.
- held_x = (state == PRESSED). prev_x is held_x delayed by one flop.
- x = held_x & ~prev_x. The pulse is exactly one cycle wide.
- Latency:
  - Key asserted and stable before edge 1: held_x rises at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - The pulse is high from that edge to the next.
  - With defaults: edge 6, high for cycle 6→7.
- Release uses the same latency and produces no pulse.
- Boundary conditions:
  - Glitch shorter than DEBOUNCE_CYCLES cycles: counter clears; no state change, no pulse.
  - Bounce during release of the same length: PRESSED holds.
  - Key held indefinitely: exactly one pulse.
  - Re-press: requires a full debounced release first.
  - Simultaneous L and R pulses: both pass through unmodified. The downstream light treats L&R as no move.
  - Reset mid-debounce or mid-pulse: pulse dropped immediately.
  - Key still held when Reset deasserts: treated as a new press, pulse after SYNC_STAGES+DEBOUNCE_CYCLES edges.
- The two keys are fully independent. No cross-key state.

Optional Feature:
- Macro: KEYCOND_PRESS_CNT_EN.
- Defined:
  - Adds outputs cnt_l and cnt_r, 8 bits each.
  - Each increments on its pulse and saturates at 255.
  - Reset clears them to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package key_pkg:
  - key_state_t enum: RELEASED = 1'b0, PRESSED = 1'b1.
  - constants KEY_PRESSED_LVL = 1'b0, KEY_SYNC_MIN = 2.
- One sub-module, key_debounce: synchronizer, FSM, counter and one-shot for one key.
  - key_conditioner instantiates key_debounce twice.
  - key_conditioner also holds the optional counters.

Test Plan:
- Reset, then drive key_l_n=0 stable from edge 1 (defaults) → held_l=1 from edge 6; L=1 only in cycle 6→7; R=0 throughout.
- Hold key_l_n=0 for 50 cycles → exactly one L pulse. Release → held_l=0 six edges after release; no pulse.
- Bounce key_r_n low for 3 cycles, high for 1, low for 3, then high → counter never reaches 4; held_r stays 0; no R pulse.
- Press both keys on the same edge → L and R both high in the same single cycle (6→7).
- Assert Reset at edge 4 of a left press while the key stays low; deassert at edge 5 → no pulse before reset. L pulses 6 edges after deassert; mid-pulse reset drops L immediately.
- With KEYCOND_PRESS_CNT_EN: 260 debounced left presses → cnt_l=255 (saturated); cnt_r=0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the tug-of-war key conditioning path.
package key_pkg;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } key_state_t;

  localparam logic KEY_PRESSED_LVL = 1'b0;
  localparam int   KEY_SYNC_MIN    = 2;
  localparam int   KEY_CNT_W       = 8;

endpackage

// File: rtl/key_debounce.sv
// One key: synchronizer, debounce FSM with run-length counter, rising-edge one-shot.
// held_o rises SYNC_STAGES+DEBOUNCE_CYCLES edges after a stable press; pulse_o is one cycle.
module key_debounce
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic held_o,
  output logic pulse_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < KEY_SYNC_MIN) begin : g_sync_chk
    $error("key_debounce: SYNC_STAGES below minimum");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  key_state_t             state_q;
  logic [CW-1:0]          cnt_q;
  logic                   prev_q;
  logic                   s;
  logic                   held;

  // Flops reset to the released level so a key held through reset counts as a new press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n_i};
    end
  end

  assign s    = (sync_q[SYNC_STAGES-1] == KEY_PRESSED_LVL);
  assign held = (state_q == PRESSED);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      prev_q <= held;
      if (s != held) begin
        if (cnt_q == CNT_LAST) begin
          state_q <= held ? RELEASED : PRESSED;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign held_o  = held;
  assign pulse_o = held & ~prev_q;

endmodule

// File: rtl/key_conditioner.sv
// Two independent debounced keys producing L/R move pulses; Reset deassertion is expected pre-synchronized.
// Optional macro KEYCOND_PRESS_CNT_EN adds saturating 8-bit press counters cnt_l/cnt_r.
module key_conditioner
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_l_n,
  input  logic key_r_n,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
`ifdef KEYCOND_PRESS_CNT_EN
  ,
  output logic [KEY_CNT_W-1:0] cnt_l,
  output logic [KEY_CNT_W-1:0] cnt_r
`endif
);

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .key_n_i (key_l_n),
    .held_o  (held_l),
    .pulse_o (L)
  );

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .key_n_i (key_r_n),
    .held_o  (held_r),
    .pulse_o (R)
  );

`ifdef KEYCOND_PRESS_CNT_EN
  logic [KEY_CNT_W-1:0] cnt_l_q;
  logic [KEY_CNT_W-1:0] cnt_r_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_l_q <= '0;
      cnt_r_q <= '0;
    end else begin
      if (L && (cnt_l_q != '1)) cnt_l_q <= cnt_l_q + 1'b1;
      if (R && (cnt_r_q != '1)) cnt_r_q <= cnt_r_q + 1'b1;
    end
  end

  assign cnt_l = cnt_l_q;
  assign cnt_r = cnt_r_q;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus random key activity against a sliding-window model.
module tb_key_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HL   = SYNC + DEB + 1;

  logic Clock = 1'b0;
  logic Reset;
  logic key_l_n;
  logic key_r_n;
  logic L, R, held_l, held_r;
`ifdef KEYCOND_PRESS_CNT_EN
  logic [7:0] cnt_l, cnt_r;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int dut_pl = 0;
  int dut_pr = 0;

  always #5 Clock = ~Clock;

  key_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .L       (L),
    .R       (R),
    .held_l  (held_l),
    .held_r  (held_r)
`ifdef KEYCOND_PRESS_CNT_EN
    ,
    .cnt_l   (cnt_l),
    .cnt_r   (cnt_r)
`endif
  );

  // Model: history of raw pressed samples, newest in bit 0. The FSM at an edge sees the
  // sample taken SYNC edges earlier; the level flips once the last DEB such samples all disagree.
  logic [HL-1:0] m_hist [2];
  logic          m_held [2];
  logic          m_prev [2];
  int            m_cnt  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = '0;
      m_held[k] = 1'b0;
      m_prev[k] = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic m_step();
    logic          p [2];
    logic [DEB-1:0] win;
    logic          flip;
    p[0] = (key_l_n === 1'b0);
    p[1] = (key_r_n === 1'b0);
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = {m_hist[k][HL-2:0], p[k]};
      win       = m_hist[k][SYNC +: DEB];
      flip      = m_held[k] ? (win == '0) : (win == '1);
      m_prev[k] = m_held[k];
      if (flip) m_held[k] = ~m_held[k];
      if (m_held[k] && !m_prev[k] && m_cnt[k] < 255) m_cnt[k]++;
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    if (Reset) m_reset();
    else m_step();
    @(negedge Clock);
    chk("L", L, m_held[0] & ~m_prev[0]);
    chk("R", R, m_held[1] & ~m_prev[1]);
    chk("held_l", held_l, m_held[0]);
    chk("held_r", held_r, m_held[1]);
`ifdef KEYCOND_PRESS_CNT_EN
    chk("cnt_l", cnt_l, m_cnt[0]);
    chk("cnt_r", cnt_r, m_cnt[1]);
`endif
    if (L === 1'b1) dut_pl++;
    if (R === 1'b1) dut_pr++;
  endtask

  initial begin
    int pl0;
    int n;
    logic r_seen;

    Reset   = 1'b0;
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    #2 Reset = 1'b1;
    m_reset();
    #1;
    chk("rst_L", L, 0);
    chk("rst_R", R, 0);
    chk("rst_held_l", held_l, 0);
    chk("rst_held_r", held_r, 0);
    repeat (2) @(negedge Clock);

    // Stable left press from edge 1, held 50 cycles, then released.
    Reset   = 1'b0;
    key_l_n = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      cyc();
      if (e == 5) chk("s1_held_e5", held_l, 0);
      if (e == 6) begin
        chk("s1_held_e6", held_l, 1);
        chk("s1_L_e6", L, 1);
      end
      if (e == 7) chk("s1_L_e7", L, 0);
    end
    chk("s1_one_L", dut_pl, 1);
    chk("s1_no_R", dut_pr, 0);
    key_l_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      if (e == 5) chk("s1_rel_held_e5", held_l, 1);
      if (e == 6) chk("s1_rel_held_e6", held_l, 0);
    end
    chk("s1_rel_noL", dut_pl, 1);

    // Right key bounce: low 3, high 1, low 3, then released.
    r_seen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      key_r_n = (i < 3 || (i >= 4 && i < 7)) ? 1'b0 : 1'b1;
      cyc();
      if (held_r === 1'b1) r_seen = 1'b1;
    end
    chk("s2_held_r_never", r_seen, 0);
    chk("s2_no_R", dut_pr, 0);

    // Both keys on the same edge.
    key_l_n = 1'b0;
    key_r_n = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      cyc();
      if (e == 6) begin
        chk("s3_L_e6", L, 1);
        chk("s3_R_e6", R, 1);
      end
      if (e == 7) begin
        chk("s3_L_e7", L, 0);
        chk("s3_R_e7", R, 0);
      end
    end
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    repeat (10) cyc();
    chk("s3_L_total", dut_pl, 2);
    chk("s3_R_total", dut_pr, 1);

    // Reset mid-debounce with the key held, then reset mid-pulse.
    pl0     = dut_pl;
    key_l_n = 1'b0;
    repeat (4) cyc();
    Reset = 1'b1;
    m_reset();
    #1;
    chk("s4_held_in_rst", held_l, 0);
    chk("s4_no_early_L", dut_pl, pl0);
    cyc();
    Reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      if (e == 5) chk("s4_L_e5", L, 0);
      if (e == 6) chk("s4_L_e6", L, 1);
    end
    chk("s4_one_L", dut_pl, pl0 + 1);
    Reset = 1'b1;
    m_reset();
    #1;
    chk("s4_L_drop", L, 0);
    chk("s4_held_drop", held_l, 0);
    cyc();
    Reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      cyc();
      if (e == 6) chk("s4_repress_L", L, 1);
    end
    key_l_n = 1'b1;
    repeat (10) cyc();

    // Random key activity with segment lengths around the debounce threshold.
    for (int seg = 0; seg < 300; seg++) begin
      key_l_n = 1'($urandom_range(0, 1));
      key_r_n = 1'($urandom_range(0, 1));
      n       = $urandom_range(1, 10);
      if ($urandom_range(0, 39) == 0) begin
        Reset = 1'b1;
        m_reset();
      end
      for (int c = 0; c < n; c++) cyc();
      Reset = 1'b0;
    end

`ifdef KEYCOND_PRESS_CNT_EN
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    Reset   = 1'b1;
    m_reset();
    cyc();
    Reset = 1'b0;
    for (int p = 0; p < 260; p++) begin
      key_l_n = 1'b0;
      repeat (7) cyc();
      key_l_n = 1'b1;
      repeat (7) cyc();
    end
    chk("cnt_l_sat", cnt_l, 255);
    chk("cnt_r_zero", cnt_r, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
